alu_muldiv_stage: RTL and testbench

Execute stage for the multi-cycle MIPS core, parametrised in data width. It combines the ALU operand source muxes, the combinational ALU and the latched ALU result register. It adds an iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake, which the control FSM polls before it reads HI/LO.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/muldiv_iter.sv | 143 ++++++++++++++
 rtl/alu_muldiv_stage.sv | 98 +++++++++
 tb/tb_alu_muldiv_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, operand selects,
// multiply/divide opcodes and the iterative unit's state enum.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic       SRC_A_PC  = 1'b0;
  localparam logic       SRC_A_REG = 1'b1;

  localparam logic [1:0] SRC_B_REG     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam int unsigned ALU_CONST_FOUR = 4;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide with HI/LO registers and start/busy/done handshake.
// Divider datapath is built only when ALU_DIV_EN is defined.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              hi_we,
  input  logic              lo_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  md_state_e           state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   acc_hi, acc_lo, m;
  logic                neg_q, err_q;
  logic                op_ok_c, go_c, last_c;
  logic                op_signed_c, a_neg_c, b_neg_c;
  logic [DATA_W-1:0]   a_mag_c, b_mag_c;
  logic [DATA_W:0]     sum_c;
  logic [DATA_W-1:0]   step_hi_c, step_lo_c, res_hi_c, res_lo_c;
  logic [2*DATA_W-1:0] prod_c;
`ifdef ALU_DIV_EN
  logic                is_div_q, neg_r_q;
  logic [DATA_W:0]     shl_c, diff_c;
`endif

  assign op_signed_c = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg_c     = op_signed_c & a[DATA_W-1];
  assign b_neg_c     = op_signed_c & b[DATA_W-1];
  assign a_mag_c     = a_neg_c ? -a : a;
  assign b_mag_c     = b_neg_c ? -b : b;
`ifdef ALU_DIV_EN
  assign op_ok_c = 1'b1;
`else
  assign op_ok_c = ~op[1];
`endif
  assign go_c   = start && (state != MD_RUN);
  assign last_c = (state == MD_RUN) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE, MD_DONE: state_nxt = start ? (op_ok_c ? MD_RUN : MD_DONE) : MD_IDLE;
      MD_RUN:           if (cnt == '0) state_nxt = MD_DONE;
      default:          state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MD_RUN);
    done = (state == MD_DONE);
    err  = (state == MD_DONE) && err_q;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    sum_c     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
    step_hi_c = sum_c[DATA_W:1];
    step_lo_c = {sum_c[0], acc_lo[DATA_W-1:1]};
`ifdef ALU_DIV_EN
    shl_c  = {acc_hi, acc_lo[DATA_W-1]};
    diff_c = shl_c - {1'b0, m};
    if (is_div_q) begin
      step_hi_c = diff_c[DATA_W] ? shl_c[DATA_W-1:0] : diff_c[DATA_W-1:0];
      step_lo_c = {acc_lo[DATA_W-2:0], ~diff_c[DATA_W]};
    end
`endif
  end

  // Sign fix-up applied to the final iteration's result.
  always_comb begin
    prod_c   = neg_q ? -{step_hi_c, step_lo_c} : {step_hi_c, step_lo_c};
    res_hi_c = prod_c[2*DATA_W-1:DATA_W];
    res_lo_c = prod_c[DATA_W-1:0];
`ifdef ALU_DIV_EN
    if (is_div_q) begin
      res_lo_c = neg_q   ? -step_lo_c : step_lo_c;
      res_hi_c = neg_r_q ? -step_hi_c : step_hi_c;
      if (m == '0) res_lo_c = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      m        <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef ALU_DIV_EN
      is_div_q <= 1'b0;
      neg_r_q  <= 1'b0;
`endif
    end else begin
      if (go_c) begin
        cnt      <= CNT_W'(DATA_W - 1);
        acc_hi   <= '0;
        acc_lo   <= a_mag_c;
        m        <= b_mag_c;
        neg_q    <= a_neg_c ^ b_neg_c;
        err_q    <= ~op_ok_c;
`ifdef ALU_DIV_EN
        is_div_q <= op[1];
        neg_r_q  <= a_neg_c;
`endif
      end else if (state == MD_RUN) begin
        cnt    <= cnt - CNT_W'(1);
        acc_hi <= step_hi_c;
        acc_lo <= step_lo_c;
      end
      // End-of-run result overrides MTHI/MTLO; writes during RUN are dropped.
      if (last_c) begin
        hi <= res_hi_c;
        lo <= res_lo_c;
      end else if (state != MD_RUN) begin
        if (hi_we) hi <= a;
        if (lo_we) lo <= a;
      end
    end
  end

endmodule

// File: rtl/alu_muldiv_stage.sv
// Execute stage: operand muxes, combinational ALU, latched result and the
// iterative multiply/divide unit (divider enabled by ALU_DIV_EN).
module alu_muldiv_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_a_sel,
  input  logic [DATA_W-1:0] reg_a,
  input  logic [DATA_W-1:0] pc,
  input  logic [1:0]        src_b_sel,
  input  logic [DATA_W-1:0] reg_b,
  input  logic [IMM_W-1:0]  imm,
  input  logic [3:0]        alu_op,
  input  logic              alu_we,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero,
  output logic [DATA_W-1:0] alu_q,
  input  logic              md_start,
  input  logic [1:0]        md_op,
  output logic              md_busy,
  output logic              md_done,
  output logic              md_err,
  input  logic              hi_we,
  input  logic              lo_we,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [DATA_W-1:0] a_c, b_c, imm_ext_c;
  logic [CNT_W-1:0]  shamt_c;

  assign imm_ext_c = DATA_W'($signed(imm));
  assign a_c       = (src_a_sel == SRC_A_REG) ? reg_a : pc;
  assign shamt_c   = b_c[CNT_W-1:0];

  always_comb begin
    b_c = reg_b;
    case (src_b_sel)
      SRC_B_REG:     b_c = reg_b;
      SRC_B_FOUR:    b_c = DATA_W'(ALU_CONST_FOUR);
      SRC_B_IMM:     b_c = imm_ext_c;
      SRC_B_IMM_SH2: b_c = imm_ext_c << 2;
      default:       b_c = reg_b;
    endcase
  end

  always_comb begin
    alu_out = '0;
    case (alu_op)
      ALU_ADD:  alu_out = a_c + b_c;
      ALU_SUB:  alu_out = a_c - b_c;
      ALU_AND:  alu_out = a_c & b_c;
      ALU_OR:   alu_out = a_c | b_c;
      ALU_XOR:  alu_out = a_c ^ b_c;
      ALU_NOR:  alu_out = ~(a_c | b_c);
      ALU_SLT:  alu_out = DATA_W'($signed(a_c) < $signed(b_c));
      ALU_SLTU: alu_out = DATA_W'(a_c < b_c);
      ALU_SLL:  alu_out = a_c << shamt_c;
      ALU_SRL:  alu_out = a_c >> shamt_c;
      ALU_SRA:  alu_out = DATA_W'($signed(a_c) >>> shamt_c);
      // Immediate's low IMM_W bits moved to the top of the word.
      ALU_LUI:  alu_out = b_c << (DATA_W - IMM_W);
      default:  alu_out = '0;
    endcase
  end

  assign zero = (alu_out == '0);

  always_ff @(posedge clk) begin
    if (rst)         alu_q <= '0;
    else if (alu_we) alu_q <= alu_out;
  end

  muldiv_iter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (md_op),
    .a     (reg_a),
    .b     (reg_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .busy  (md_busy),
    .done  (md_done),
    .err   (md_err),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_alu_muldiv_stage.sv
// Directed bench for alu_muldiv_stage; expectations follow ALU_DIV_EN.
module tb_alu_muldiv_stage;
  import alu_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              src_a_sel;
  logic [DATA_W-1:0] reg_a, pc, reg_b;
  logic [1:0]        src_b_sel;
  logic [IMM_W-1:0]  imm;
  logic [3:0]        alu_op;
  logic              alu_we;
  logic [DATA_W-1:0] alu_out, alu_q, hi, lo;
  logic              zero;
  logic              md_start, md_busy, md_done, md_err, hi_we, lo_we;
  logic [1:0]        md_op;

  int errors = 0;
  int checks = 0;

  logic [3:0]  t_op  [12] = '{ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
                              ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, 4'd15};
  logic [31:0] t_a   [12] = '{32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h80000000,
                              32'h80000000, 32'hFFFFFFFF, 32'd5};
  logic [31:0] t_b   [12] = '{32'd5, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h0,
                              32'h1, 32'h1, 32'd31, 32'h24, 32'd4, 32'h1, 32'd5};
  logic [31:0] t_exp [12] = '{32'h0, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0,
                              32'hFFFFFFFF, 32'h1, 32'h0, 32'h80000000, 32'h08000000,
                              32'hF8000000, 32'h0, 32'h0};

  always #5 clk = ~clk;

  alu_muldiv_stage #(.DATA_W(DATA_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .src_a_sel(src_a_sel), .reg_a(reg_a), .pc(pc),
    .src_b_sel(src_b_sel), .reg_b(reg_b), .imm(imm), .alu_op(alu_op),
    .alu_we(alu_we), .alu_out(alu_out), .zero(zero), .alu_q(alu_q),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .md_done(md_done),
    .md_err(md_err), .hi_we(hi_we), .lo_we(lo_we), .hi(hi), .lo(lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, then scramble the operand buses.
  task automatic md_go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op    = op;
    reg_a    = a;
    reg_b    = b;
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    reg_a    = 32'hDEADBEEF;
    reg_b    = 32'h0BADF00D;
  endtask

  // Returns the cycle index of md_done (0 if it never came).
  task automatic wait_done(input int first, output int cyc);
    cyc = 0;
    for (int c = first; c <= first + 100; c++) begin
      if (md_done) begin
        cyc = c;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int cyc;
    int pulses;

    src_a_sel = 1'b1; reg_a = 32'hA5A5A5A5; pc = 32'h44; src_b_sel = 2'd0;
    reg_b = 32'h3; imm = 16'h8001; alu_op = ALU_ADD; alu_we = 1'b1;
    md_start = 1'b1; md_op = MD_MULT; hi_we = 1'b1; lo_we = 1'b1;
    ticks(2);
    chk("rst_alu_q", alu_q, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_done", md_done, 0);
    chk("rst_err", md_err, 0);
    rst = 1'b0; md_start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; alu_we = 1'b0;

    src_a_sel = SRC_A_PC; pc = 32'h100; src_b_sel = SRC_B_IMM_SH2; imm = 16'hFFFF;
    alu_op = ALU_ADD;
    #1;
    chk("pc_plus_imm", alu_out, 32'hFC);
    chk("pc_plus_imm_zero", zero, 0);
    alu_we = 1'b1;
    tick();
    chk("alu_q_load", alu_q, 32'hFC);
    alu_we = 1'b0; pc = 32'h200;
    tick();
    chk("alu_q_hold", alu_q, 32'hFC);

    src_a_sel = SRC_A_REG; src_b_sel = SRC_B_REG;
    for (int i = 0; i < 12; i++) begin
      alu_op = t_op[i]; reg_a = t_a[i]; reg_b = t_b[i];
      #1;
      chk($sformatf("alu_vec%0d", i), alu_out, t_exp[i]);
      chk($sformatf("zero_vec%0d", i), zero, t_exp[i] == 32'h0);
    end
    src_b_sel = SRC_B_IMM; imm = 16'h1234; alu_op = ALU_LUI;
    #1;
    chk("lui", alu_out, 32'h12340000);
    src_b_sel = SRC_B_FOUR; reg_a = 32'h8; alu_op = ALU_ADD;
    #1;
    chk("plus_four", alu_out, 32'hC);

    md_go(MD_MULT, 32'hFFFFFFFE, 32'd3);
    chk("mult_busy", md_busy, 1);
    wait_done(1, cyc);
    chk("mult_latency", cyc, 33);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    chk("mult_err", md_err, 0);

    // Start from DONE, with a stray start pulse mid-run.
    md_go(MD_MULTU, 32'hFFFFFFFE, 32'd3);
    ticks(3);
    md_start = 1'b1; md_op = MD_DIVU; reg_a = 32'd7; reg_b = 32'd0;
    tick();
    md_start = 1'b0;
    chk("multu_busy", md_busy, 1);
    wait_done(5, cyc);
    chk("multu_latency", cyc, 33);
    chk("multu_hi", hi, 32'h2);
    chk("multu_lo", lo, 32'hFFFFFFFA);
    tick();
    chk("idle_after_done", md_done, 0);

`ifdef ALU_DIV_EN
    md_go(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(1, cyc);
    chk("div_latency", cyc, 33);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_err", md_err, 0);
    md_go(MD_DIVU, 32'd5, 32'd0);
    wait_done(1, cyc);
    chk("divu0_latency", cyc, 33);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'd5);
    md_go(MD_DIV, 32'hFFFFFFF9, 32'd0);
    wait_done(1, cyc);
    chk("div0_lo", lo, 32'hFFFFFFFF);
    chk("div0_hi", hi, 32'hFFFFFFF9);
    md_go(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(1, cyc);
    chk("divmin_lo", lo, 32'h80000000);
    chk("divmin_hi", hi, 32'h0);
    tick();
`else
    md_go(MD_DIV, 32'hFFFFFFF9, 32'd2);
    chk("nodiv_done", md_done, 1);
    chk("nodiv_err", md_err, 1);
    chk("nodiv_busy", md_busy, 0);
    chk("nodiv_hi", hi, 32'h2);
    chk("nodiv_lo", lo, 32'hFFFFFFFA);
    tick();
    chk("nodiv_done_clr", md_done, 0);
    chk("nodiv_err_clr", md_err, 0);
`endif

    hi_we = 1'b1; reg_a = 32'h1234;
    tick();
    hi_we = 1'b0;
    chk("mthi_idle", hi, 32'h1234);
    lo_we = 1'b1; reg_a = 32'h5678;
    tick();
    lo_we = 1'b0;
    chk("mtlo_idle", lo, 32'h5678);
    md_go(MD_MULTU, 32'd2, 32'd3);
    ticks(9);
    hi_we = 1'b1; reg_a = 32'h5555;
    tick();
    hi_we = 1'b0;
    chk("mthi_run_ignored", hi, 32'h1234);
    ticks(21);
    hi_we = 1'b1; reg_a = 32'h7777;
    tick();
    hi_we = 1'b0;
    chk("end_run_done", md_done, 1);
    chk("end_run_hi_wins", hi, 32'h0);
    chk("end_run_lo", lo, 32'h6);
    tick();

    md_go(MD_MULT, 32'hFFFFFFFE, 32'd3);
    ticks(9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", md_busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_done) pulses++;
      tick();
    end
    chk("abort_no_done", pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
